// File: rtl/mac_resp_checker_if.sv
// Bus between the mac stimulus/observation side and the response checker.
// The master drives the stimulus and z; the slave (checker) returns status.
interface mac_resp_checker_if #(
  parameter int CNT_W = 16
);
  logic             clr;
  logic             in_valid;
  logic [15:0]      a;
  logic [15:0]      b;
  logic [31:0]      c;
  logic             ct1;
  logic             ct2;
  logic [32:0]      z;
  logic             stop_on_err;
  logic             mismatch;
  logic [32:0]      exp_z;
  logic [CNT_W-1:0] chk_cnt;
  logic [CNT_W-1:0] err_cnt;
  logic [32:0]      first_err_exp;
  logic [32:0]      first_err_obs;
  logic             frozen;

  modport master (
    output clr, in_valid, a, b, c, ct1, ct2, z, stop_on_err,
    input  mismatch, exp_z, chk_cnt, err_cnt, first_err_exp, first_err_obs, frozen
  );

  modport slave (
    input  clr, in_valid, a, b, c, ct1, ct2, z, stop_on_err,
    output mismatch, exp_z, chk_cnt, err_cnt, first_err_exp, first_err_obs, frozen
  );
endinterface

// File: rtl/mac_resp_checker.sv
// Response checker for mac: rebuilds the expected result from the tapped stimulus,
// delays it by LATENCY cycles and compares against z, counting checks and errors.
module mac_resp_checker #(
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  mac_resp_checker_if.slave  bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FROZEN = 2'd2} state_e;

  state_e                    state_q, state_d;
  logic                      hold, accept, do_cmp, miss;
  logic [31:0]               prod;
  logic [32:0]               e_new, tail_e;
  logic [32:0]               acc_q;
  logic [LATENCY-1:0]        vld_pipe_q;
  logic [LATENCY-1:0][32:0]  e_pipe_q;
  logic [CNT_W-1:0]          chk_cnt_q, err_cnt_q;
  logic                      mismatch_q, first_seen_q;
  logic [32:0]               exp_z_q, first_exp_q, first_obs_q;

  // Reference result; all modes wrap modulo 2^33.
  assign prod = 32'(bus.a) * 32'(bus.b);
  always_comb begin
    e_new = {1'b0, prod};
    case ({bus.ct2, bus.ct1})
      2'b00:   e_new = {1'b0, prod};
      2'b01:   e_new = {1'b0, prod} + {1'b0, bus.c};
      2'b10:   e_new = {1'b0, bus.c} - {1'b0, prod};
      default: e_new = acc_q + {1'b0, prod};
    endcase
  end

  assign tail_e = e_pipe_q[LATENCY-1];

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (miss && bus.stop_on_err) state_d = FROZEN;
      FROZEN:  state_d = FROZEN;
      default: state_d = IDLE;
    endcase
    if (bus.clr) state_d = IDLE;
  end

  // FSM: outputs / datapath enables
  always_comb begin
    hold   = (state_q == FROZEN);
    accept = bus.in_valid && !hold;
    do_cmp = vld_pipe_q[LATENCY-1] && !hold;
    miss   = do_cmp && (bus.z != tail_e);
  end

  // Bubbles travel through the pipe so compare timing stays fixed to LATENCY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      e_pipe_q   <= '0;
      acc_q      <= '0;
    end else if (bus.clr) begin
      vld_pipe_q <= '0;
      e_pipe_q   <= '0;
      acc_q      <= '0;
    end else if (!hold) begin
      vld_pipe_q[0] <= accept;
      e_pipe_q[0]   <= e_new;
      for (int i = 1; i < LATENCY; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        e_pipe_q[i]   <= e_pipe_q[i-1];
      end
      if (accept) acc_q <= e_new;
    end
  end

  // clr outranks a same-edge compare: nothing is counted or captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      mismatch_q   <= 1'b0;
      first_seen_q <= 1'b0;
      exp_z_q      <= '0;
      first_exp_q  <= '0;
      first_obs_q  <= '0;
    end else if (bus.clr) begin
      chk_cnt_q    <= '0;
      err_cnt_q    <= '0;
      mismatch_q   <= 1'b0;
      first_seen_q <= 1'b0;
      exp_z_q      <= '0;
      first_exp_q  <= '0;
      first_obs_q  <= '0;
    end else begin
      mismatch_q <= miss;
      if (do_cmp) begin
        exp_z_q <= tail_e;
        if (chk_cnt_q != {CNT_W{1'b1}}) chk_cnt_q <= chk_cnt_q + CNT_W'(1);
      end
      if (miss) begin
        if (err_cnt_q != {CNT_W{1'b1}}) err_cnt_q <= err_cnt_q + CNT_W'(1);
        if (!first_seen_q) begin
          first_seen_q <= 1'b1;
          first_exp_q  <= tail_e;
          first_obs_q  <= bus.z;
        end
      end
    end
  end

  assign bus.mismatch      = mismatch_q;
  assign bus.exp_z         = exp_z_q;
  assign bus.chk_cnt       = chk_cnt_q;
  assign bus.err_cnt       = err_cnt_q;
  assign bus.first_err_exp = first_exp_q;
  assign bus.first_err_obs = first_obs_q;
  assign bus.frozen        = (state_q == FROZEN);
endmodule

// File: tb/tb_mac_resp_checker.sv
// Randomized bench for mac_resp_checker at LATENCY 1 and 4, checked against a
// history-table reference model built from the arithmetic rules.
module tb_mac_resp_checker;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_resp_checker_if #(.CNT_W(16)) if1 ();
  mac_resp_checker_if #(.CNT_W(16)) if4 ();

  mac_resp_checker #(.LATENCY(1), .CNT_W(16)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  mac_resp_checker #(.LATENCY(4), .CNT_W(16)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  int checks = 0;
  int fails  = 0;
  bit quiet  = 1'b0;

  // reference model state, index 0 -> LATENCY 1, index 1 -> LATENCY 4
  int          lat [2] = '{1, 4};
  int          n = 16;
  bit          hv   [2][16];
  logic [32:0] he   [2][16];
  logic [32:0] macc [2];
  int          mchk [2], merr [2];
  bit          mmis [2], mfrz [2], mfirst [2];
  logic [32:0] mexp [2], mfe [2], mfo [2];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [32:0] ref_e(input bit [1:0] m, input logic [15:0] a,
                                        input logic [15:0] b, input logic [31:0] c,
                                        input logic [32:0] acc);
    logic [32:0] p;
    p = 33'(a) * 33'(b);
    case (m)
      2'd0:    return p;
      2'd1:    return p + 33'(c);
      2'd2:    return 33'(c) - p;
      default: return acc + p;
    endcase
  endfunction

  task automatic mreset(input int d);
    for (int i = 0; i < 16; i++) hv[d][i] = 1'b0;
    macc[d] = '0; mchk[d] = 0; merr[d] = 0; mmis[d] = 0; mfrz[d] = 0; mfirst[d] = 0;
    mexp[d] = '0; mfe[d] = '0; mfo[d] = '0;
  endtask

  task automatic check_all();
    chk("mis_l1",  64'(if1.mismatch),      64'(mmis[0]));
    chk("expz_l1", 64'(if1.exp_z),         64'(mexp[0]));
    chk("chk_l1",  64'(if1.chk_cnt),       64'(mchk[0]));
    chk("err_l1",  64'(if1.err_cnt),       64'(merr[0]));
    chk("fexp_l1", 64'(if1.first_err_exp), 64'(mfe[0]));
    chk("fobs_l1", 64'(if1.first_err_obs), 64'(mfo[0]));
    chk("frz_l1",  64'(if1.frozen),        64'(mfrz[0]));
    chk("mis_l4",  64'(if4.mismatch),      64'(mmis[1]));
    chk("expz_l4", 64'(if4.exp_z),         64'(mexp[1]));
    chk("chk_l4",  64'(if4.chk_cnt),       64'(mchk[1]));
    chk("err_l4",  64'(if4.err_cnt),       64'(merr[1]));
    chk("fexp_l4", 64'(if4.first_err_exp), 64'(mfe[1]));
    chk("fobs_l4", 64'(if4.first_err_obs), 64'(mfo[1]));
    chk("frz_l4",  64'(if4.frozen),        64'(mfrz[1]));
  endtask

  task automatic drive_idle();
    if1.clr = 0; if1.in_valid = 0; if1.a = 0; if1.b = 0; if1.c = 0;
    if1.ct1 = 0; if1.ct2 = 0; if1.z = 0; if1.stop_on_err = 0;
    if4.clr = 0; if4.in_valid = 0; if4.a = 0; if4.b = 0; if4.c = 0;
    if4.ct1 = 0; if4.ct2 = 0; if4.z = 0; if4.stop_on_err = 0;
  endtask

  // One clock: drive at negedge, z is the due expected value xor mask, then model the edge.
  task automatic step(input bit v, input logic [15:0] a, input logic [15:0] b,
                      input logic [31:0] c, input bit [1:0] m, input logic [32:0] mask,
                      input bit clr, input bit stop);
    logic [32:0] zz [2];
    logic [32:0] e;
    int so, sn;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      so = (n - lat[d]) % 16;
      if (hv[d][so] && !mfrz[d]) zz[d] = he[d][so] ^ mask;
      else                       zz[d] = 33'({$urandom(), $urandom()});
    end
    if1.clr = clr; if1.in_valid = v; if1.a = a; if1.b = b; if1.c = c;
    if1.ct1 = m[0]; if1.ct2 = m[1]; if1.stop_on_err = stop; if1.z = zz[0];
    if4.clr = clr; if4.in_valid = v; if4.a = a; if4.b = b; if4.c = c;
    if4.ct1 = m[0]; if4.ct2 = m[1]; if4.stop_on_err = stop; if4.z = zz[1];
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      so = (n - lat[d]) % 16;
      sn = n % 16;
      if (clr) mreset(d);
      else if (mfrz[d]) begin
        mmis[d] = 0; hv[d][sn] = 0;
      end else begin
        mmis[d] = 0;
        if (hv[d][so]) begin
          if (mchk[d] < 65535) mchk[d]++;
          mexp[d] = he[d][so];
          if (zz[d] != he[d][so]) begin
            if (merr[d] < 65535) merr[d]++;
            mmis[d] = 1;
            if (!mfirst[d]) begin mfirst[d] = 1; mfe[d] = he[d][so]; mfo[d] = zz[d]; end
            if (stop) mfrz[d] = 1;
          end
        end
        if (v) begin
          e = ref_e(m, a, b, c, macc[d]);
          macc[d] = e; hv[d][sn] = 1; he[d][sn] = e;
        end else hv[d][sn] = 0;
      end
    end
    n++;
    #1;
    if (!quiet) check_all();
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive_idle();
    #1;
    mreset(0); mreset(1);
    check_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    drive_idle();
    for (int d = 0; d < 2; d++) mreset(d);
    do_reset();

    // T1: mode 00, 3*5
    step(1, 3, 5, 0, 2'd0, 0, 0, 0);
    idle(1);
    chk("t1_expz", 64'(if1.exp_z), 64'd15);
    chk("t1_chk",  64'(if1.chk_cnt), 64'd1);
    chk("t1_err",  64'(if1.err_cnt), 64'd0);

    // T2: mode 01 then accumulate in mode 11
    step(1, 2, 3, 10, 2'd1, 0, 0, 0);
    step(1, 1, 1, 0, 2'd3, 0, 0, 0);
    chk("t2_expz0", 64'(if1.exp_z), 64'd16);
    step(1, 16'hFFFF, 16'hFFFF, 0, 2'd3, 0, 0, 0);
    chk("t2_expz1", 64'(if1.exp_z), 64'd17);
    idle(1);
    chk("t2_expz2", 64'(if1.exp_z), 64'h0_FFFE_0012);

    // T3: mode 10 underflow, z forced to 0
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 2'd2, 0, 0, 0);
    step(0, 0, 0, 0, 0, 33'h1_FFFF_FFFF, 0, 0);
    chk("t3_mis",  64'(if1.mismatch), 64'd1);
    chk("t3_err",  64'(if1.err_cnt), 64'd1);
    chk("t3_fexp", 64'(if1.first_err_exp), 64'h1_FFFF_FFFF);
    chk("t3_fobs", 64'(if1.first_err_obs), 64'd0);
    idle(1);
    chk("t3_pulse", 64'(if1.mismatch), 64'd0);

    // T4: freeze on 2nd compare, stop_on_err drop does not unfreeze, clr exits
    step(0, 0, 0, 0, 0, 0, 1, 1);
    step(1, 16'($urandom()), 16'($urandom()), $urandom(), 2'd1, 0, 0, 1);
    step(1, 16'($urandom()), 16'($urandom()), $urandom(), 2'd0, 0, 0, 1);
    step(1, 16'($urandom()), 16'($urandom()), $urandom(), 2'd3, 33'h4, 0, 1);
    step(1, 16'($urandom()), 16'($urandom()), $urandom(), 2'd2, 0, 0, 1);
    for (int i = 0; i < 10; i++) step(1, 7, 9, 0, 2'd0, 33'h1, 0, 0);
    chk("t4_frz", 64'(if1.frozen), 64'd1);
    chk("t4_chk", 64'(if1.chk_cnt), 64'd2);
    chk("t4_err", 64'(if1.err_cnt), 64'd1);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    chk("t4_clr_frz", 64'(if1.frozen), 64'd0);
    chk("t4_clr_chk", 64'(if1.chk_cnt), 64'd0);

    // T5: LATENCY 4 with a bubble
    step(1, 11, 13, 0, 2'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 21, 2, 5, 2'd1, 0, 0, 0);
    step(1, 4, 4, 0, 2'd3, 0, 0, 0);
    idle(1);
    chk("t5_chk1", 64'(if4.chk_cnt), 64'd1);
    idle(3);
    chk("t5_chk3", 64'(if4.chk_cnt), 64'd3);
    idle(2);
    chk("t5_chk3b", 64'(if4.chk_cnt), 64'd3);

    // mode 11 wrap to zero, no error
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 1, 1, 0, 2'd2, 0, 0, 0);
    step(1, 1, 1, 0, 2'd3, 0, 0, 0);
    idle(1);
    chk("wrap_expz", 64'(if1.exp_z), 64'd0);
    chk("wrap_err",  64'(if1.err_cnt), 64'd0);

    // clr and a failing compare on the same edge
    step(0, 0, 0, 0, 0, 0, 1, 0);
    step(1, 3, 3, 0, 2'd0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 33'h1, 1, 0);
    chk("clrwin_err", 64'(if1.err_cnt), 64'd0);
    chk("clrwin_mis", 64'(if1.mismatch), 64'd0);

    // T6: reset with 3 samples in flight at LATENCY 4
    step(1, 5, 6, 7, 2'd1, 0, 0, 0);
    step(1, 8, 9, 1, 2'd0, 0, 0, 0);
    step(1, 2, 2, 2, 2'd3, 0, 0, 0);
    do_reset();
    idle(6);
    chk("t6_chk4", 64'(if4.chk_cnt), 64'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      logic [32:0] mask;
      mask = ($urandom_range(0, 9) == 0) ? 33'(1 << $urandom_range(0, 32)) : 33'd0;
      step($urandom_range(0, 9) < 7, 16'($urandom()), 16'($urandom()), $urandom(),
           2'($urandom()), mask, $urandom_range(0, 39) == 0, $urandom_range(0, 9) == 0);
    end

    // counter saturation
    step(0, 0, 0, 0, 0, 0, 1, 0);
    quiet = 1'b1;
    for (int i = 0; i < 65540; i++)
      step(1, 16'($urandom()), 16'($urandom()), $urandom(), 2'($urandom()), 0, 0, 0);
    quiet = 1'b0;
    idle(5);
    chk("sat_chk1", 64'(if1.chk_cnt), 64'hFFFF);
    chk("sat_chk4", 64'(if4.chk_cnt), 64'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
